turbo_encoder_core: RTL
=======================

// Module: turbo_encoder_core
// PURPOSE
//  Dual-constituent LTE turbo encoder core: two identical 8-state RSC encoders (g0=1+D^2+D^3, g1=1+D+D^3).
//  RSC1 takes natural-order bits; RSC2 takes interleaved bits from the interleaver, beat-aligned.
//  Runtime block length K, valid/ready streaming on both sides, 3-cycle trellis termination.
//  Sits between the interleaver and the rate matcher. Successor to the fixed two-size single encoder.
// PARAMETERS
//  K_W    13    width of k_len and the internal beat counter
//  K_MIN  40    smallest legal block length
//  K_MAX  6144  largest legal block length (must be < 2**K_W)
// PORTS
//  clk        in   1    rising-edge clock
//  aclr_n     in   1    asynchronous active-low reset
//  start      in   1    block start pulse; k_len is sampled with it
//  k_len      in   K_W  block length K for this block
//  in_valid   in   1    ck/ckp beat valid
//  in_ready   out  1    core accepts a beat this cycle
//  ck         in   1    natural-order input bit
//  ckp        in   1    interleaved input bit
//  out_valid  out  1    output beat valid
//  out_ready  in   1    downstream accepts the output beat
//  out_x1     out  1    data: ck; tail: RSC1 tail systematic bit
//  out_z1     out  1    RSC1 parity
//  out_x2     out  1    data: ckp; tail: RSC2 tail systematic bit
//  out_z2     out  1    RSC2 parity
//  out_tail   out  1    current output beat is a tail beat
//  out_last   out  1    final tail beat of the block
//  busy       out  1    state != IDLE
//  k_err      out  1    one-cycle pulse: start rejected, k_len out of range
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, both shift registers (q0,q1,q2) = 0, counter = 0.
//  RSC step, per encoder with input u:
//   s  = u^q1^q2
//   z  = s^q0^q2
//   state update {q0,q1,q2} <= {s,q0,q1}
//  Tail step: u = q1^q2, so s = 0. Tail x = q1^q2; tail z = q0^q2. State is 000 after 3 tail steps.
//  FSM IDLE:
//   - start and K_MIN <= k_len <= K_MAX: latch K, clear q, counter = 0, go to DATA.
//   - start with k_len out of range: k_err pulse, stay IDLE.
//  FSM DATA:
//   - in_ready = !out_valid | out_ready.
//   - Each in_valid&in_ready: step both RSCs, load the output register, counter++.
//   - Acceptance of beat K-1: go to TAIL, counter = 0.
//  FSM TAIL:
//   - in_ready = 0. A tail beat is produced whenever the output slot is free (!out_valid | out_ready).
//   - Both RSCs terminate in parallel; out_tail = 1.
//   - Third tail beat: out_last = 1, go to IDLE.
//  Latency: 1 cycle from input acceptance to out_valid. The registered output holds stable while out_valid & !out_ready.
//  Throughput: 1 beat/cycle without backpressure; K+3 output beats per block.
//  Simultaneous events:
//   - start while busy is ignored (no k_err).
//   - start in the cycle the last tail beat is produced is ignored.
//   - start may arrive the cycle after returning to IDLE.
//  in_valid outside DATA: ignored, never consumed.
//  aclr_n low mid-block: immediate return to reset values; the partial block is dropped with no out_last.
// CONFIGURATION
//  ENC_STATE_DBG_EN defined:
//   - adds dbg_s1[2:0] and dbg_s2[2:0] outputs carrying {q0,q1,q2} of RSC1 and RSC2 (reset 0).
//   - adds dbg_cnt[K_W-1:0] output carrying the live beat counter.
//  Not defined: these ports are absent and the encoding behaviour is identical.
// TESTING
//  1. K=40, all-zero ck/ckp, out_ready=1:
//     - 43 output beats, all data bits 0.
//     - out_tail on beats 41-43, out_last on beat 43 only; busy falls after it.
//  2. K=40, ck=1 on beat 0 only, ckp=0:
//     - out_z1 beats 0-4 = 1,1,1,1,0; out_z2 all 0 in data.
//     - dbg_s1 = 000 after the tail (ENC_STATE_DBG_EN).
//  3. Backpressure, K=6144 random data, out_ready toggling 50%:
//     - output stream matches a golden model bit-exactly.
//     - no beat lost or duplicated; output holds while stalled.
//  4. start with k_len=39, then 6145:
//     - k_err pulses each time; busy stays 0; no output.
//     - k_len=40 then accepted.
//  5. aclr_n low at beat 500 of K=1056:
//     - all outputs 0 within the same cycle; a new K=40 block encodes correctly.
//  6. start pulsed during DATA and TAIL: ignored.
//     Back-to-back blocks K=40 then K=1056: both golden-exact.

Source files
------------

// File: rtl/turbo_encoder_core.sv
// turbo_encoder_core
//   LTE turbo encoder core with two identical 8-state RSC constituent encoders.
//   The generator polynomials are g0 = 1+D^2+D^3 (feedback) and g1 = 1+D+D^3
//   (parity). RSC1 encodes the natural-order bit ck. RSC2 encodes the
//   interleaved bit ckp, which arrives on the same beat. The block length K
//   is set at runtime. The core emits K data beats and then 3 trellis
//   termination beats that run on both encoders in parallel.
//
// Ports
//   clk, aclr_n             rising-edge clock, asynchronous active-low reset
//   start, k_len            block start pulse; k_len is sampled with it
//   in_valid/in_ready       input beat handshake carrying ck and ckp
//   out_valid/out_ready     output beat handshake
//   out_x1, out_z1          RSC1 systematic/tail bit and parity
//   out_x2, out_z2          RSC2 systematic/tail bit and parity
//   out_tail, out_last      tail beat flag; final tail beat of the block
//   busy                    core is inside a block (not IDLE)
//   k_err                   one-cycle pulse when a start is rejected
//
// Optional build macro ENC_STATE_DBG_EN
//   Adds dbg_s1/dbg_s2 ({q0,q1,q2} of each encoder) and dbg_cnt (beat counter).

module turbo_encoder_core #(
  parameter int K_W   = 13,
  parameter int K_MIN = 40,
  parameter int K_MAX = 6144
) (
  input  logic           clk,
  input  logic           aclr_n,
  input  logic           start,
  input  logic [K_W-1:0] k_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           ck,
  input  logic           ckp,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_x1,
  output logic           out_z1,
  output logic           out_x2,
  output logic           out_z2,
  output logic           out_tail,
  output logic           out_last,
  output logic           busy,
  output logic           k_err
`ifdef ENC_STATE_DBG_EN
  ,
  output logic [2:0]     dbg_s1,
  output logic [2:0]     dbg_s2,
  output logic [K_W-1:0] dbg_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  localparam logic [K_W-1:0] K_MIN_V = K_W'(K_MIN);
  localparam logic [K_W-1:0] K_MAX_V = K_W'(K_MAX);
  localparam logic [K_W-1:0] TAIL_LAST = K_W'(2);

  state_t         state, state_next;
  logic [K_W-1:0] cnt;
  logic [K_W-1:0] k_last;
  // Each encoder register is packed as {q0,q1,q2}, with q0 in bit 2.
  logic [2:0]     r1, r2;

  logic slot_free;
  logic k_ok;
  logic take_data, take_tail, accept_start, reject_start;
  logic u1, s1, z1, u2, s2, z2;

  assign slot_free = !out_valid || out_ready;
  assign k_ok      = (k_len >= K_MIN_V) && (k_len <= K_MAX_V);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and handshake decode. A start pulse only matters in IDLE, so a
  // start that arrives during DATA or TAIL is dropped without raising k_err.
  // This includes a start in the cycle that produces the last tail beat.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    take_data    = 1'b0;
    take_tail    = 1'b0;
    accept_start = 1'b0;
    reject_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (k_ok) begin
            accept_start = 1'b1;
            state_next   = DATA;
          end else begin
            reject_start = 1'b1;
          end
        end
      end
      DATA: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          take_data = 1'b1;
          if (cnt == k_last) state_next = TAIL;
        end
      end
      TAIL: begin
        if (slot_free) begin
          take_tail = 1'b1;
          if (cnt == TAIL_LAST) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // RSC step for both encoders. During termination the input is chosen as
  // q1^q2, which forces the feedback bit s to zero. That input is also the
  // tail systematic bit.
  always_comb begin
    u1 = take_tail ? (r1[1] ^ r1[0]) : ck;
    s1 = u1 ^ r1[1] ^ r1[0];
    z1 = s1 ^ r1[2] ^ r1[0];
    u2 = take_tail ? (r2[1] ^ r2[0]) : ckp;
    s2 = u2 ^ r2[1] ^ r2[0];
    z2 = s2 ^ r2[2] ^ r2[0];
  end

  // Datapath. The output register loads only when the slot is free, so a
  // stalled beat holds still until it is taken. The beat counter restarts at
  // 0 whenever the FSM changes phase.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      cnt       <= '0;
      k_last    <= '0;
      r1        <= '0;
      r2        <= '0;
      out_valid <= 1'b0;
      out_x1    <= 1'b0;
      out_z1    <= 1'b0;
      out_x2    <= 1'b0;
      out_z2    <= 1'b0;
      out_tail  <= 1'b0;
      out_last  <= 1'b0;
      k_err     <= 1'b0;
    end else begin
      k_err <= reject_start;
      if (accept_start) begin
        k_last <= k_len - K_W'(1);
        r1     <= '0;
        r2     <= '0;
        cnt    <= '0;
      end
      if (take_data || take_tail) begin
        r1        <= {s1, r1[2:1]};
        r2        <= {s2, r2[2:1]};
        out_valid <= 1'b1;
        out_x1    <= u1;
        out_z1    <= z1;
        out_x2    <= u2;
        out_z2    <= z2;
        out_tail  <= take_tail;
        out_last  <= take_tail && (cnt == TAIL_LAST);
        cnt       <= (state_next != state) ? '0 : cnt + K_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef ENC_STATE_DBG_EN
  assign dbg_s1  = r1;
  assign dbg_s2  = r2;
  assign dbg_cnt = cnt;
`endif

endmodule
